button_ctrl_wb8: RTL and testbench
==================================

Name: button_ctrl_wb8

Overview:
Wishbone 8-bit slave that owns the board push-buttons: synchronises and debounces the active-low button inputs and latches press/release events. It raises a level interrupt to the SPU32 core under a per-button mask. It sits on the 8-bit peripheral bus beside the other wb8 peripherals and replaces raw button polling with clean, event-driven access.

Parameters:
NUM_BUTTONS, 5, number of buttons; legal range 1..7.
TICK_DIV, 1000, clock cycles per debounce tick; must be at least 2.
DEBOUNCE_TICKS, 10, consecutive ticks an input must differ from the stable state before it is accepted; legal range 1..255.

Ports:
I_wb_clk  in  1  system/bus clock
I_reset_n  in  1  asynchronous active-low reset
I_wb_stb  in  1  bus strobe
I_wb_we  in  1  write enable
I_wb_adr  in  2  register address
I_wb_dat  in  8  write data
O_wb_dat  out  8  read data
O_wb_ack  out  1  bus acknowledge
I_button  in  NUM_BUTTONS  raw pins; 0 = pressed
O_irq  out  1  level interrupt, active-high

Behaviour:
- Reset is asynchronous, active-low; one clock domain. While I_reset_n=0: O_wb_ack=0, O_wb_dat=0, O_irq=0. Synchroniser flops = all 1 (released). Stable state = 0 (released). Event latches = 0. IRQ_EN = 0. Prescaler and debounce counters = 0.
- Synchroniser: two flops per button, then invert, giving pressed=1.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when the count equals TICK_DIV-1.
- Debounce, per button (states SETTLED, COUNTING):
  - SETTLED: sync==stable; counter held at 0. On sync!=stable, go to COUNTING.
  - COUNTING: on each tick, counter+1.
  - If sync returns to stable before acceptance: counter cleared, back to SETTLED, no event.
  - When counter+1 reaches DEBOUNCE_TICKS on a tick: stable<=sync, counter cleared, back to SETTLED. Set the PRESS bit (0->1) or the RELEASE bit (1->0).
  - Latency from pin edge to stable change: between 2+(DEBOUNCE_TICKS-1)*TICK_DIV+1 and 2+DEBOUNCE_TICKS*TICK_DIV+1 cycles.
- Register map (bits above NUM_BUTTONS read 0 unless stated):
  - 0 STATE: read-only, debounced pressed=1. Writes ignored.
  - 1 PRESS: press events. Write-1-to-clear.
  - 2 RELEASE: release events. Write-1-to-clear.
  - 3 IRQ_EN: read/write. Bits[NUM_BUTTONS-1:0] = per-button press interrupt enable. Bit 7 = release interrupt enable, covering all buttons. Unused bits read 0.
- Bus handshake:
  - O_wb_ack <= I_wb_stb & ~O_wb_ack, so each access gets exactly one ack pulse one cycle after stb.
  - The master holds stb/adr/we/dat until ack and drops stb in the ack cycle. Back-to-back strobes therefore get an ack every second cycle.
  - Read data is registered in the same edge that raises ack. O_wb_dat holds its last value otherwise.
  - Writes take effect at the edge that raises ack.
- Simultaneous event set and W1C clear of the same bit in one cycle: set wins, bit stays 1.
- O_irq registered: O_irq <= |(PRESS & IRQ_EN[NB-1:0]) | (IRQ_EN[7] & |RELEASE). It stays asserted until the relevant bits are cleared or disabled.
- Reset mid-debounce or mid-access: all state is discarded. No event or ack is produced after reset release until new stimulus arrives.
- Button held across reset release: reported as a PRESS event after the normal debounce latency.

Decomposition:
- Shared include button_ctrl_defs.vh holds the register address constants (ADR_STATE=0, ADR_PRESS=1, ADR_RELEASE=2, ADR_IRQEN=3) and IRQ_EN_REL_BIT=7.
- One sub-module, button_debounce: a single-button synchroniser plus counter with inputs clk, reset_n, tick, raw_n and outputs stable, rise_pulse, fall_pulse. Instantiate it NUM_BUTTONS times with a generate loop.
- Prescaler, event latches and bus decode live in the top.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3):
- After reset, read each of addresses 0..3 -> ack one cycle after stb; data 0x00; O_irq=0.
- Drive I_button[2]=0 steadily -> STATE=0x04 and PRESS=0x04 within 11..15 cycles of the edge. Then write IRQ_EN=0x04 -> O_irq=1 within 2 cycles. Write PRESS=0x04 -> O_irq=0.
- Glitch I_button[0] low for 6 cycles, then high -> STATE and PRESS stay 0x00; no interrupt.
- Press then release button 4 with IRQ_EN=0x80 -> RELEASE=0x10 and O_irq=1. Write RELEASE=0xFF -> RELEASE=0x00 and O_irq=0. Writes to STATE leave it unchanged.
- Time a W1C of PRESS bit 1 to land on the tick where button 1 is accepted -> PRESS bit 1 reads 1 afterwards.
- Assert I_reset_n=0 mid-debounce with I_button[3]=0 held -> all outputs 0 at once. After release, PRESS=0x08 appears after the full debounce latency.

Source files
------------

// File: rtl/button_ctrl_wb8_pkg.sv
// Shared register map and debounce state type for the wb8 push-button controller.
package button_ctrl_wb8_pkg;

    localparam logic [1:0] ADR_STATE   = 2'd0;
    localparam logic [1:0] ADR_PRESS   = 2'd1;
    localparam logic [1:0] ADR_RELEASE = 2'd2;
    localparam logic [1:0] ADR_IRQEN   = 2'd3;

    localparam int unsigned IRQ_EN_REL_BIT = 7;

    typedef enum logic {
        DB_SETTLED,
        DB_COUNTING
    } db_state_t;

endpackage

// File: rtl/button_ctrl_wb8_debounce.sv
// Single-button two-flop synchroniser and tick-based debouncer; raw_n is active-low.
module button_debounce
    import button_ctrl_wb8_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw_n,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_stable;
    logic [7:0] r_cnt;
    db_state_t  r_state;
    logic       w_pressed;
    logic       w_accept;

    assign w_pressed = ~r_sync2;

    // Pulses are combinational so the event latches set on the same edge the stable state flips.
    assign w_accept   = (r_state == DB_COUNTING) && (w_pressed != r_stable) && tick
                        && ((r_cnt + 8'd1) == 8'(DEBOUNCE_TICKS));
    assign rise_pulse = w_accept & w_pressed;
    assign fall_pulse = w_accept & ~w_pressed;
    assign stable     = r_stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_state  <= DB_SETTLED;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
            case (r_state)
                DB_SETTLED: begin
                    r_cnt <= '0;
                    if (w_pressed != r_stable) r_state <= DB_COUNTING;
                end
                DB_COUNTING: begin
                    if (w_pressed == r_stable) begin
                        r_cnt   <= '0;
                        r_state <= DB_SETTLED;
                    end else if (w_accept) begin
                        r_stable <= w_pressed;
                        r_cnt    <= '0;
                        r_state  <= DB_SETTLED;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= DB_SETTLED;
            endcase
        end
    end

endmodule

// File: rtl/button_ctrl_wb8.sv
// Wishbone 8-bit push-button controller: debounced state, W1C press/release latches, masked level IRQ.
module button_ctrl_wb8
    import button_ctrl_wb8_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS    = 5,
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic                   I_wb_clk,
    input  logic                   I_reset_n,
    input  logic                   I_wb_stb,
    input  logic                   I_wb_we,
    input  logic [1:0]             I_wb_adr,
    input  logic [7:0]             I_wb_dat,
    output logic [7:0]             O_wb_dat,
    output logic                   O_wb_ack,
    input  logic [NUM_BUTTONS-1:0] I_button,
    output logic                   O_irq
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0]          r_presc;
    logic [NUM_BUTTONS-1:0] r_press;
    logic [NUM_BUTTONS-1:0] r_release;
    logic [NUM_BUTTONS-1:0] r_irq_en_btn;
    logic                   r_irq_en_rel;

    logic                   w_tick;
    logic [NUM_BUTTONS-1:0] w_stable;
    logic [NUM_BUTTONS-1:0] w_rise;
    logic [NUM_BUTTONS-1:0] w_fall;
    logic                   w_acc;
    logic                   w_wr;
    logic [NUM_BUTTONS-1:0] w_clr_press;
    logic [NUM_BUTTONS-1:0] w_clr_release;
    logic [7:0]             w_rdata;
    logic                   w_unused;

    assign w_unused = ^I_wb_dat;
    assign w_tick   = (r_presc == PW'(TICK_DIV - 1));

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_db (
            .clk        (I_wb_clk),
            .reset_n    (I_reset_n),
            .tick       (w_tick),
            .raw_n      (I_button[g]),
            .stable     (w_stable[g]),
            .rise_pulse (w_rise[g]),
            .fall_pulse (w_fall[g])
        );
    end

    assign w_acc         = I_wb_stb & ~O_wb_ack;
    assign w_wr          = w_acc & I_wb_we;
    assign w_clr_press   = (w_wr && I_wb_adr == ADR_PRESS)   ? I_wb_dat[NUM_BUTTONS-1:0] : '0;
    assign w_clr_release = (w_wr && I_wb_adr == ADR_RELEASE) ? I_wb_dat[NUM_BUTTONS-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        case (I_wb_adr)
            ADR_STATE:   w_rdata = 8'(w_stable);
            ADR_PRESS:   w_rdata = 8'(r_press);
            ADR_RELEASE: w_rdata = 8'(r_release);
            ADR_IRQEN: begin
                w_rdata                 = 8'(r_irq_en_btn);
                w_rdata[IRQ_EN_REL_BIT] = r_irq_en_rel;
            end
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_presc      <= '0;
            r_press      <= '0;
            r_release    <= '0;
            r_irq_en_btn <= '0;
            r_irq_en_rel <= 1'b0;
            O_wb_ack     <= 1'b0;
            O_wb_dat     <= '0;
            O_irq        <= 1'b0;
        end else begin
            r_presc  <= w_tick ? '0 : r_presc + PW'(1);
            O_wb_ack <= w_acc;
            if (w_acc && !I_wb_we) O_wb_dat <= w_rdata;
            if (w_wr && I_wb_adr == ADR_IRQEN) begin
                r_irq_en_btn <= I_wb_dat[NUM_BUTTONS-1:0];
                r_irq_en_rel <= I_wb_dat[IRQ_EN_REL_BIT];
            end
            // Clear first, then OR in new events so a same-cycle set survives the W1C.
            r_press   <= (r_press & ~w_clr_press) | w_rise;
            r_release <= (r_release & ~w_clr_release) | w_fall;
            O_irq     <= (|(r_press & r_irq_en_btn)) | (r_irq_en_rel & (|r_release));
        end
    end

endmodule

// File: tb/tb_button_ctrl_wb8.sv
// Bench for button_ctrl_wb8: event-level model checked every cycle plus directed literal checks.
module tb_button_ctrl_wb8;
    import button_ctrl_wb8_pkg::*;

    localparam int NB = 5;
    localparam int TD = 4;
    localparam int DT = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          stb   = 1'b0;
    logic          we    = 1'b0;
    logic [1:0]    adr   = '0;
    logic [7:0]    wdat  = '0;
    logic [NB-1:0] btn   = '1;
    logic [7:0]    O_wb_dat;
    logic          O_wb_ack;
    logic          O_irq;

    button_ctrl_wb8 #(
        .NUM_BUTTONS   (NB),
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .I_wb_clk  (clk),
        .I_reset_n (rst_n),
        .I_wb_stb  (stb),
        .I_wb_we   (we),
        .I_wb_adr  (adr),
        .I_wb_dat  (wdat),
        .O_wb_dat  (O_wb_dat),
        .O_wb_ack  (O_wb_ack),
        .I_button  (btn),
        .O_irq     (O_irq)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: raw pins pass a 2-deep delay queue; a button is accepted once its synced level has
    // disagreed with the stable level across DT prescaler ticks, not counting the first cycle seen.
    logic [NB-1:0] m_h0 = '1, m_h1 = '1, m_stable = '0, m_press = '0, m_rel = '0, m_ien = '0;
    logic          m_ienrel = 1'b0, m_ack = 1'b0, m_irq = 1'b0;
    logic [7:0]    m_dat = '0;
    int            m_edges = 0;
    int            m_run[NB];
    int            m_tk[NB];

    function automatic logic [7:0] m_reg(input logic [1:0] a);
        logic [7:0] v;
        v = '0;
        case (a)
            2'd0: v[NB-1:0] = m_stable;
            2'd1: v[NB-1:0] = m_press;
            2'd2: v[NB-1:0] = m_rel;
            default: begin
                v[NB-1:0] = m_ien;
                v[7]      = m_ienrel;
            end
        endcase
        return v;
    endfunction

    function automatic bit m_accepts(input int b);
        bit tick;
        bit mis;
        tick = (m_edges % TD) == TD - 1;
        mis  = (~m_h1[b]) != m_stable[b];
        return mis && (m_run[b] >= 1) && tick && (m_tk[b] + 1 == DT);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [NB-1:0] synced, rise, fall;
        logic [7:0]    rd;
        bit            tick, ackn;
        if (!rst_n) begin
            m_h0 = '1; m_h1 = '1; m_stable = '0; m_press = '0; m_rel = '0; m_ien = '0;
            m_ienrel = 0; m_ack = 0; m_irq = 0; m_dat = '0; m_edges = 0;
            for (int b = 0; b < NB; b++) begin m_run[b] = 0; m_tk[b] = 0; end
        end else begin
            tick   = (m_edges % TD) == TD - 1;
            synced = ~m_h1;
            rise   = '0;
            fall   = '0;
            ackn   = stb & ~m_ack;
            rd     = m_reg(adr);
            m_irq  = (|(m_press & m_ien)) | (m_ienrel & (|m_rel));
            for (int b = 0; b < NB; b++) begin
                if (synced[b] != m_stable[b]) begin
                    if (m_run[b] >= 1 && tick) m_tk[b]++;
                    if (m_tk[b] == DT) begin
                        m_stable[b] = synced[b];
                        if (synced[b]) rise[b] = 1'b1; else fall[b] = 1'b1;
                        m_run[b] = 0;
                        m_tk[b]  = 0;
                    end else begin
                        m_run[b]++;
                    end
                end else begin
                    m_run[b] = 0;
                    m_tk[b]  = 0;
                end
            end
            if (ackn && we) begin
                case (adr)
                    2'd1: m_press = m_press & ~wdat[NB-1:0];
                    2'd2: m_rel   = m_rel & ~wdat[NB-1:0];
                    2'd3: begin m_ien = wdat[NB-1:0]; m_ienrel = wdat[7]; end
                    default: ;
                endcase
            end
            if (ackn && !we) m_dat = rd;
            m_press = m_press | rise;
            m_rel   = m_rel | fall;
            m_ack   = ackn;
            m_h1    = m_h0;
            m_h0    = btn;
            m_edges++;
        end
    end

    always @(negedge clk) begin
        check("cyc_ack", O_wb_ack, m_ack);
        check("cyc_dat", O_wb_dat, m_dat);
        check("cyc_irq", O_irq, m_irq);
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] q);
        int n;
        @(negedge clk);
        stb = 1'b1; we = w; adr = a; wdat = d; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!O_wb_ack && n < 4);
        check(w ? "wr_ack_latency" : "rd_ack_latency", n, 1);
        q = O_wb_dat;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] q);
        bus(1'b0, a, 8'h00, q);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        logic [7:0] q;
        int         lat;
        time        t0;
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        for (int a = 0; a < 4; a++) begin
            rd(2'(a), q);
            check($sformatf("reset_read_adr%0d", a), q, 8'h00);
        end
        check("reset_irq", O_irq, 0);

        idle(1);
        btn[2] = 1'b0; t0 = $time; q = '0; lat = 0;
        while (!q[2] && lat < 20) begin rd(ADR_STATE, q); lat++; end
        lat = int'(($time - t0) / 10);
        check("press2_latency_in_window", int'(lat >= 13 && lat <= 17), 1);
        check("press2_state", q, 8'h04);
        rd(ADR_PRESS, q);   check("press2_press", q, 8'h04);
        wr(ADR_IRQEN, 8'h04); idle(2);
        check("press2_irq_on", O_irq, 1);
        wr(ADR_PRESS, 8'h04); idle(2);
        check("press2_irq_off", O_irq, 0);
        rd(ADR_PRESS, q);   check("press2_cleared", q, 8'h00);

        idle(1); btn[2] = 1'b1; idle(25);
        rd(ADR_RELEASE, q); check("release2", q, 8'h04);
        wr(ADR_RELEASE, 8'hFF); wr(ADR_IRQEN, 8'h00);

        idle(1); btn[0] = 1'b0; idle(6); btn[0] = 1'b1; idle(25);
        rd(ADR_STATE, q);   check("glitch_state", q, 8'h00);
        rd(ADR_PRESS, q);   check("glitch_press", q, 8'h00);
        check("glitch_irq", O_irq, 0);

        wr(ADR_IRQEN, 8'h80);
        idle(1); btn[4] = 1'b0; idle(25); btn[4] = 1'b1; idle(25);
        rd(ADR_RELEASE, q); check("release4", q, 8'h10);
        check("release4_irq_on", O_irq, 1);
        wr(ADR_RELEASE, 8'hFF); idle(2);
        check("release4_irq_off", O_irq, 0);
        rd(ADR_RELEASE, q); check("release4_cleared", q, 8'h00);
        wr(ADR_STATE, 8'hFF);
        rd(ADR_STATE, q);   check("state_write_ignored", q, 8'h00);
        wr(ADR_PRESS, 8'hFF);
        wr(ADR_IRQEN, 8'hFF);
        rd(ADR_IRQEN, q);   check("irqen_unused_bits", q, 8'h9F);
        wr(ADR_IRQEN, 8'h00);
        rd(ADR_PRESS, q);   check("press_all_cleared", q, 8'h00);

        idle(1); btn[1] = 1'b0; lat = 0;
        while (!m_accepts(1) && lat < 60) begin @(negedge clk); lat++; end
        check("race_edge_found", int'(lat < 60), 1);
        stb = 1'b1; we = 1'b1; adr = ADR_PRESS; wdat = 8'h02;
        @(negedge clk);
        check("race_ack", O_wb_ack, 1);
        stb = 1'b0; we = 1'b0;
        rd(ADR_PRESS, q);   check("race_set_wins", q, 8'h02);
        wr(ADR_PRESS, 8'h02);
        rd(ADR_PRESS, q);   check("race_later_clear", q, 8'h00);

        idle(1); btn[1] = 1'b1; idle(25);
        wr(ADR_IRQEN, 8'h80);
        rd(ADR_IRQEN, q);   check("pre_reset_irqen", q, 8'h80);
        check("pre_reset_irq", O_irq, 1);
        idle(1); btn[3] = 1'b0; idle(8);
        #2 rst_n = 1'b0;
        #1;
        check("reset_now_ack", O_wb_ack, 0);
        check("reset_now_dat", O_wb_dat, 0);
        check("reset_now_irq", O_irq, 0);
        idle(3);
        rst_n = 1'b1; t0 = $time; q = '0; lat = 0;
        while (!q[3] && lat < 20) begin rd(ADR_PRESS, q); lat++; end
        lat = int'(($time - t0) / 10);
        check("held_across_reset_latency", int'(lat >= 13 && lat <= 17), 1);
        check("held_across_reset_press", q, 8'h08);
        rd(ADR_RELEASE, q); check("post_reset_release", q, 8'h00);
        rd(ADR_IRQEN, q);   check("post_reset_irqen", q, 8'h00);
        rd(ADR_STATE, q);   check("post_reset_state", q, 8'h08);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
